// File: rtl/bloom_filter_writer.sv
// Insert-side writer for a shared Bloom bit array: hashes one flow key into NUM_HASH
// single-bit writes, or sweeps the whole array to zero. Optional INSERT_COUNT_EN adds insert_count.
module bloom_filter_writer #(
  parameter int NUM_HASH = 3,
  parameter int ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [71:0]       ip_pro,
  input  logic [15:0]       src_port,
  input  logic [15:0]       dest_port,
  input  logic              insert_valid,
  output logic              readyIns,
  input  logic              clear_req,
  output logic              bf_wr_en,
  output logic [ADDR_W-1:0] bf_wr_addr,
  output logic              bf_wr_data,
  output logic              ins_done,
  output logic              clear_done
`ifdef INSERT_COUNT_EN
  ,
  output logic [15:0]       insert_count
`endif
);

  localparam logic [2:0] LAST_HASH = 3'(NUM_HASH - 1);

  typedef enum logic [1:0] {IDLE, HASH, CLEAR, DONE} state_t;

  state_t            state;
  logic [103:0]      key_p0;
  logic [2:0]        hash_cnt;
  logic [ADDR_W-1:0] clr_cnt;
  logic              clear_pend;
  logic              op_clear;

  // Byte j of the key is rotated by (i+j) mod 8; the 3-bit add wraps for free.
  function automatic logic [ADDR_W-1:0] hash_index(input logic [103:0] k, input logic [2:0] i);
    logic [7:0]  h;
    logic [15:0] t;
    logic [2:0]  r;
    h = {5'b0, i} * 8'h5B;
    for (int j = 0; j < 13; j++) begin
      r = i + 3'(j);
      t = {k[8*j +: 8], k[8*j +: 8]} << r;
      h = h ^ t[15:8];
    end
    return ADDR_W'(h);
  endfunction

`ifdef INSERT_COUNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      readyIns   <= 1'b0;
      bf_wr_en   <= 1'b0;
      bf_wr_addr <= '0;
      bf_wr_data <= 1'b0;
      ins_done   <= 1'b0;
      clear_done <= 1'b0;
      clear_pend <= 1'b0;
      op_clear   <= 1'b0;
      key_p0     <= '0;
      hash_cnt   <= '0;
      clr_cnt    <= '0;
`ifdef INSERT_COUNT_EN
      insert_count <= '0;
`endif
    end else begin
      bf_wr_en   <= 1'b0;
      bf_wr_data <= 1'b0;
      ins_done   <= 1'b0;
      clear_done <= 1'b0;
      case (state)
        IDLE: begin
          if (!readyIns) begin
            // First cycle out of reset: only advertise readiness.
            readyIns   <= 1'b1;
            clear_pend <= clear_pend | clear_req;
          end else if (clear_req || clear_pend) begin
            state      <= CLEAR;
            clr_cnt    <= '0;
            clear_pend <= 1'b0;
            op_clear   <= 1'b1;
            readyIns   <= 1'b0;
          end else if (insert_valid) begin
            state    <= HASH;
            key_p0   <= {ip_pro, src_port, dest_port};
            hash_cnt <= '0;
            op_clear <= 1'b0;
            readyIns <= 1'b0;
          end
        end
        HASH: begin
          bf_wr_en   <= 1'b1;
          bf_wr_data <= 1'b1;
          bf_wr_addr <= hash_index(key_p0, hash_cnt);
          hash_cnt   <= hash_cnt + 3'd1;
          clear_pend <= clear_pend | clear_req;
          if (hash_cnt == LAST_HASH) state <= DONE;
        end
        CLEAR: begin
          bf_wr_en   <= 1'b1;
          bf_wr_data <= 1'b0;
          bf_wr_addr <= clr_cnt;
          clr_cnt    <= clr_cnt + 1'b1;
          clear_pend <= clear_pend | clear_req;
          if (&clr_cnt) state <= DONE;
        end
        DONE: begin
          ins_done   <= ~op_clear;
          clear_done <= op_clear;
          readyIns   <= 1'b1;
          clear_pend <= clear_pend | clear_req;
          state      <= IDLE;
`ifdef INSERT_COUNT_EN
          insert_count <= op_clear ? 16'd0 : sat_inc16(insert_count);
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bloom_filter_writer.sv
// Directed bench for bloom_filter_writer: a transaction-level model predicts every output
// cycle, plus literal hash and timing expectations for specific keys.
module tb_bloom_filter_writer;
  localparam int NUM_HASH = 3;
  localparam int ADDR_W   = 8;
  localparam int DEPTH    = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [71:0]       ip_pro = '0;
  logic [15:0]       src_port = '0;
  logic [15:0]       dest_port = '0;
  logic              insert_valid = 1'b0;
  logic              clear_req = 1'b0;
  logic              readyIns;
  logic              bf_wr_en;
  logic [ADDR_W-1:0] bf_wr_addr;
  logic              bf_wr_data;
  logic              ins_done;
  logic              clear_done;
`ifdef INSERT_COUNT_EN
  logic [15:0]       insert_count;
`endif

  bloom_filter_writer #(.NUM_HASH(NUM_HASH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .ip_pro(ip_pro), .src_port(src_port), .dest_port(dest_port),
    .insert_valid(insert_valid), .readyIns(readyIns), .clear_req(clear_req),
    .bf_wr_en(bf_wr_en), .bf_wr_addr(bf_wr_addr), .bf_wr_data(bf_wr_data),
    .ins_done(ins_done), .clear_done(clear_done)
`ifdef INSERT_COUNT_EN
    , .insert_count(insert_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: hash straight from the arithmetic definition.
  function automatic logic [ADDR_W-1:0] model_hash(input logic [103:0] k, input int i);
    int h, b, r;
    h = (i * 91) % 256;
    for (int j = 0; j < 13; j++) begin
      b = int'(k[8*j +: 8]);
      r = (i + j) % 8;
      h = h ^ (((b << r) | (b >> (8 - r))) & 255);
    end
    return ADDR_W'(h);
  endfunction

  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic              data;
    logic              ins;
    logic              clr;
    logic              rdy;
  } out_t;

  function automatic out_t mk(input logic en, input logic [ADDR_W-1:0] a, input logic d,
                              input logic ins, input logic clr, input logic rdy);
    out_t o;
    o.en = en; o.addr = a; o.data = d; o.ins = ins; o.clr = clr; o.rdy = rdy;
    return o;
  endfunction

  out_t        m_q[$];
  out_t        m_cur = '0;
  bit          m_pend = 1'b0;
  int          m_acc = 0;
  logic [15:0] m_cnt = '0;

  // Each accepted operation expands into its whole future output trace.
  task automatic model_step();
    logic [103:0] k;
    if (!reset) begin
      m_q.delete(); m_cur = '0; m_pend = 1'b0; m_cnt = '0;
    end else begin
      if (m_q.size() != 0) begin
        m_cur = m_q.pop_front();
        m_pend = m_pend | clear_req;
      end else if (!m_cur.rdy) begin
        m_cur = mk(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        m_pend = m_pend | clear_req;
      end else begin
        m_cur = mk(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        if (clear_req || m_pend) begin
          m_pend = 1'b0;
          m_q.push_back(mk(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0));
          for (int a = 0; a < DEPTH; a++) m_q.push_back(mk(1'b1, ADDR_W'(a), 1'b0, 1'b0, 1'b0, 1'b0));
          m_q.push_back(mk(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1));
          m_cur = m_q.pop_front();
        end else if (insert_valid) begin
          k = {ip_pro, src_port, dest_port};
          m_acc++;
          m_q.push_back(mk(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0));
          for (int i = 0; i < NUM_HASH; i++) m_q.push_back(mk(1'b1, model_hash(k, i), 1'b1, 1'b0, 1'b0, 1'b0));
          m_q.push_back(mk(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1));
          m_cur = m_q.pop_front();
        end
      end
      if (m_cur.ins && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (m_cur.clr) m_cnt = '0;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge reset);
    model_step();
  end

  logic [ADDR_W-1:0] wr_log[$];
  logic              wr_dlog[$];
  int                ins_seen = 0;
  int                clr_seen = 0;

  // Cycle-by-cycle comparison against the model, plus a log of observed writes.
  initial forever begin
    logic [63:0] act, exp;
    @(negedge clk);
    act = 64'({bf_wr_en, bf_wr_en ? bf_wr_addr : {ADDR_W{1'b0}}, bf_wr_en & bf_wr_data,
               ins_done, clear_done, readyIns});
    exp = 64'({m_cur.en, m_cur.en ? m_cur.addr : {ADDR_W{1'b0}}, m_cur.en & m_cur.data,
               m_cur.ins, m_cur.clr, m_cur.rdy});
`ifdef INSERT_COUNT_EN
    act = (act << 16) | 64'(insert_count);
    exp = (exp << 16) | 64'(m_cnt);
`endif
    check("cycle_outputs", act, exp);
    if (bf_wr_en) begin
      wr_log.push_back(bf_wr_addr);
      wr_dlog.push_back(bf_wr_data);
    end
    if (ins_done) ins_seen++;
    if (clear_done) clr_seen++;
  end

  function automatic logic [15:0] log_at(input int i);
    return (i < wr_log.size()) ? 16'(wr_log[i]) : 16'hDEAD;
  endfunction

  function automatic bit m_idle();
    return (m_q.size() == 0) && m_cur.rdy && !m_pend;
  endfunction

  task automatic wait_idle(input string name, input int budget);
    bit ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clk);
      if (m_idle()) ok = 1'b1;
    end
    check(name, 64'(ok), 64'd1);
  endtask

  task automatic wait_accept(input string name, input int prev, input int budget);
    bit ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clk);
      if (m_acc != prev) ok = 1'b1;
    end
    check(name, 64'(ok), 64'd1);
  endtask

  task automatic scramble();
    ip_pro    = 72'({$urandom(), $urandom(), $urandom()});
    src_port  = 16'($urandom());
    dest_port = 16'($urandom());
  endtask

  task automatic do_insert(input logic [71:0] ip, input logic [15:0] sp, input logic [15:0] dp);
    int prev;
    @(negedge clk);
    ip_pro = ip; src_port = sp; dest_port = dp; insert_valid = 1'b1;
    prev = m_acc;
    wait_accept("insert_accept", prev, 400);
    insert_valid = 1'b0;
    scramble();
  endtask

  task automatic wait_writes(input int n);
    for (int c = 0; c < 50 && wr_log.size() < n; c++) @(negedge clk);
    check("writes_reached", 64'(wr_log.size() >= n), 64'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, required finish before timeout");
    $fatal(1);
  end

  initial begin
    logic [7:0]   exp_zero[3] = '{8'h00, 8'h5B, 8'hB6};
    logic [7:0]   exp_b0[3]   = '{8'h01, 8'h59, 8'hB2};
    logic [7:0]   exp_b12[3]  = '{8'h08, 8'h4B, 8'h96};
    logic [71:0]  ip_a = 72'hC0_A9_01_1E_C0_A8_01_1E_1E;
    logic [103:0] key_a, key_b;
    logic [15:0]  first[3];
    int           prev, snap_ins, snap_clr;

    key_a = {ip_a, 16'd16538, 16'd37281};
    key_b = {72'h11_22_33_44_55_66_77_88_99, 16'hABCD, 16'h0F0F};

    // Model pins against hand-computed hashes.
    for (int i = 0; i < 3; i++) begin
      check("pin_zero_key", 64'(model_hash('0, i)), 64'(exp_zero[i]));
      check("pin_b0_key", 64'(model_hash(104'd1, i)), 64'(exp_b0[i]));
      check("pin_b12_key", 64'(model_hash({8'h80, 96'd0}, i)), 64'(exp_b12[i]));
    end

    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({readyIns, bf_wr_en, bf_wr_addr, bf_wr_data, ins_done, clear_done}), 64'd0);

    // Release with an all-zero key already presented.
    insert_valid = 1'b1;
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check("t1_ready_rise", 64'({readyIns, bf_wr_en}), 64'b10);
    @(posedge clk); #1;
    check("t1_accept_ready_low", 64'({readyIns, bf_wr_en}), 64'b00);
    insert_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("t1_write", 64'({readyIns, bf_wr_en, bf_wr_data, bf_wr_addr}), 64'({3'b011, exp_zero[i]}));
    end
    @(posedge clk); #1;
    check("t1_done", 64'({readyIns, bf_wr_en, ins_done, clear_done}), 64'b1010);
    wait_idle("t1_idle", 20);

    // Literal-address inserts of single-byte keys.
    wr_log.delete();
    do_insert(72'd0, 16'd0, 16'd1);
    wait_idle("b0_idle", 20);
    for (int i = 0; i < 3; i++) check("b0_addr", 64'(log_at(i)), 64'(exp_b0[i]));
    wr_log.delete();
    do_insert({8'h80, 64'd0}, 16'd0, 16'd0);
    wait_idle("b12_idle", 20);
    for (int i = 0; i < 3; i++) check("b12_addr", 64'(log_at(i)), 64'(exp_b12[i]));

    // Reference key, then the same key again.
    wr_log.delete();
    do_insert(ip_a, 16'd16538, 16'd37281);
    wait_idle("key_a_idle", 20);
    check("key_a_count", 64'(wr_log.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      first[i] = log_at(i);
      check("key_a_addr", 64'(first[i]), 64'(model_hash(key_a, i)));
    end
    wr_log.delete();
    do_insert(ip_a, 16'd16538, 16'd37281);
    wait_idle("key_a2_idle", 20);
    for (int i = 0; i < 3; i++) check("key_a_repeat", 64'(log_at(i)), 64'(first[i]));

    // Full clear from idle.
    wr_log.delete(); wr_dlog.delete();
    snap_clr = clr_seen;
    @(negedge clk); clear_req = 1'b1;
    @(negedge clk); clear_req = 1'b0;
    wait_idle("clear_idle", 400);
    check("clear_count", 64'(wr_log.size()), 64'(DEPTH));
    check("clear_first", 64'(log_at(0)), 64'd0);
    check("clear_last", 64'(log_at(DEPTH-1)), 64'(DEPTH-1));
    check("clear_done_seen", 64'(clr_seen - snap_clr), 64'd1);

    // Clear and insert together: clear first, held insert afterwards.
    wr_log.delete(); wr_dlog.delete();
    @(negedge clk);
    ip_pro = key_b[103:32]; src_port = key_b[31:16]; dest_port = key_b[15:0];
    insert_valid = 1'b1; clear_req = 1'b1;
    prev = m_acc;
    @(negedge clk); clear_req = 1'b0;
    check("both_not_accepted", 64'(m_acc - prev), 64'd0);
    wait_accept("both_insert_accept", prev, 400);
    insert_valid = 1'b0; scramble();
    wait_idle("both_idle", 20);
    check("both_count", 64'(wr_log.size()), 64'(DEPTH + 3));
    check("both_first_is_clear", 64'(wr_dlog.size() > 0 ? wr_dlog[0] : 1'b1), 64'd0);
    check("both_insert_addr", 64'(log_at(DEPTH)), 64'(model_hash(key_b, 0)));

    // Clear requested mid-insert runs after the insert completes.
    wr_log.delete();
    snap_ins = ins_seen; snap_clr = clr_seen;
    do_insert(ip_a, 16'd1, 16'd2);
    wait_writes(2);
    clear_req = 1'b1;
    @(negedge clk); clear_req = 1'b0;
    wait_idle("pend_idle", 400);
    check("pend_ins_done", 64'(ins_seen - snap_ins), 64'd1);
    check("pend_clear_done", 64'(clr_seen - snap_clr), 64'd1);
    check("pend_writes", 64'(wr_log.size()), 64'(3 + DEPTH));

    // Held valid with a new key while busy: second key waits its turn.
    wr_log.delete();
    @(negedge clk);
    ip_pro = key_a[103:32]; src_port = key_a[31:16]; dest_port = key_a[15:0]; insert_valid = 1'b1;
    prev = m_acc;
    wait_accept("b2b_first", prev, 20);
    ip_pro = key_b[103:32]; src_port = key_b[31:16]; dest_port = key_b[15:0];
    prev = m_acc;
    wait_accept("b2b_second", prev, 20);
    insert_valid = 1'b0; scramble();
    wait_idle("b2b_idle", 20);
    for (int i = 0; i < 3; i++) begin
      check("b2b_key_a", 64'(log_at(i)), 64'(model_hash(key_a, i)));
      check("b2b_key_b", 64'(log_at(i + 3)), 64'(model_hash(key_b, i)));
    end

    // Reset in the middle of an insert.
    wr_log.delete();
    snap_ins = ins_seen;
    do_insert(ip_a, 16'd7, 16'd9);
    wait_writes(2);
    #2 reset = 1'b0;
    #1;
    check("abort_outputs", 64'({readyIns, bf_wr_en, bf_wr_addr, bf_wr_data, ins_done, clear_done}), 64'd0);
`ifdef INSERT_COUNT_EN
    check("abort_count", 64'(insert_count), 64'd0);
`endif
    @(negedge clk); #1 reset = 1'b1;
    #1 check("abort_ready_low", 64'(readyIns), 64'd0);
    @(posedge clk); #1;
    check("abort_ready_rise", 64'(readyIns), 64'd1);
    repeat (5) @(negedge clk);
    check("abort_no_more_writes", 64'(wr_log.size()), 64'd2);
    check("abort_no_done", 64'(ins_seen - snap_ins), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
